// File: rtl/lpc_cycle_fifo.sv
// lpc_cycle_fifo: captures one LPC cycle record per READY pulse, optionally
// filters it by I/O address window and cycle type, and buffers it in a FIFO
// presented as a valid/ready stream. Records lost to a full FIFO are flagged
// with a sticky overflow bit and counted in a saturating drop counter.
module lpc_cycle_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter bit          FILTER_EN = 1'b1,
  parameter logic [15:0] ADDR_MIN  = 16'h0000,
  parameter logic [15:0] ADDR_MAX  = 16'hFFFF
) (
  input  logic                       clk_i,
  input  logic                       nrst_i,
  input  logic [31:0]                tdata_i,
  input  logic                       ready_i,
  input  logic                       clr_i,
  output logic [31:0]                m_tdata_o,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              ready_q;
  logic              overflow_q;
  logic [7:0]        drop_cnt_q;

  logic              capture;
  logic              rec_ok;
  logic              accept;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  // Window check done as 17-bit signed differences so the default full
  // window does not degenerate into a constant comparison.
  function automatic logic in_window(input logic [15:0] addr);
    logic signed [16:0] d_lo;
    logic signed [16:0] d_hi;
    d_lo = $signed({1'b0, addr})     - $signed({1'b0, ADDR_MIN});
    d_hi = $signed({1'b0, ADDR_MAX}) - $signed({1'b0, addr});
    return (d_lo[16] == 1'b0) && (d_hi[16] == 1'b0);
  endfunction

  // Only real I/O cycles are buffered: type 01 (write) or 11 (read).
  function automatic logic type_ok(input logic [1:0] cyc_type);
    return cyc_type[0];
  endfunction

  // Drop counter saturates so firmware never sees a wrapped small count.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Capture, filter and push/pop decisions for the current edge.
  always_comb begin
    capture = ready_i & ~ready_q;
    rec_ok  = type_ok(tdata_i[1:0]) & in_window(tdata_i[27:12]);
    accept  = capture & ((FILTER_EN == 1'b0) | rec_ok);
    full    = (level_q == LVL_W'(DEPTH));
    pop     = m_tvalid_o & m_tready_i;
    push    = accept & (~full | pop);
    drop    = accept & full & ~pop;
  end

  // Control state: edge detector, pointers, level and overflow status.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ready_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      ready_q <= ready_i;
      if (clr_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level_q    <= '0;
        overflow_q <= 1'b0;
        drop_cnt_q <= 8'h00;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      level_q <= level_q + LVL_W'(1);
        else if (pop && !push) level_q <= level_q - LVL_W'(1);
        if (drop) begin
          overflow_q <= 1'b1;
          drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
      end
    end
  end

  // Record storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr] <= tdata_i;
  end

  // Head of FIFO is shown directly, forced to zero when empty.
  always_comb begin
    m_tvalid_o = (level_q != '0);
    m_tdata_o  = m_tvalid_o ? mem[rd_ptr] : '0;
    level_o    = level_q;
    overflow_o = overflow_q;
    drop_cnt_o = drop_cnt_q;
  end

endmodule
